// File: rtl/irq_seq_pkg.sv
// irq_seq_pkg: shared types and constants for the interrupt entry/exit sequencer.
package irq_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD      = 3'd3,
        S_CHK     = 3'd4,
        S_VEC     = 3'd5,
        S_EOI_REQ = 3'd6,
        S_EOI_WR  = 3'd7
    } state_t;

    // Bus master phases
    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_REQ  = 2'd1,
        B_ACT  = 2'd2
    } bus_phase_t;

    // irq_ctrl register offsets
    localparam logic [7:0] IRQ_REG_STATUS = 8'h00;
    localparam logic [7:0] IRQ_REG_EOI    = 8'h08;

    // Status register layout
    localparam int STAT_VALID_BIT = 7;
    localparam int STAT_NUM_MSB   = 4;
    localparam int STAT_NUM_LSB   = 0;

    // Vector address for an interrupt number; plain 32-bit wrap-around
    function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                             input logic [4:0]  num,
                                             input int          shift);
        return base + ({27'd0, num} << shift);
    endfunction

endpackage

// File: rtl/irq_seq_bus.sv
// irq_seq_bus: 8-bit peripheral bus master. A start pulse latches the access,
// raises bus_req, waits for bus_gnt, drives cs_/oe_/we_ for the access window
// and drops everything on the final cycle. done marks that final cycle;
// rdata holds the byte sampled there for reads.
module irq_seq_bus
    import irq_seq_pkg::*;
#(
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       cs_,
    output logic       oe_,
    output logic       we_,
    output logic       done,
    output logic [7:0] rdata
);

    // Reads hold strobes RD_WAIT cycles, writes exactly one
    localparam logic [2:0] RD_LAST = 3'(RD_WAIT - 1);

    bus_phase_t phase;
    logic [2:0] cnt;
    logic       wr_q;

    // Access completes on the edge that ends this cycle
    assign done = (phase == B_ACT) && (cnt == 3'd0);

    // Request / strobe sequencing; a grant drop mid-access is ignored
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase    <= B_IDLE;
            bus_req  <= 1'b0;
            cs_      <= 1'b1;
            oe_      <= 1'b1;
            we_      <= 1'b1;
            addr     <= 8'h00;
            data_out <= 8'h00;
            rdata    <= 8'h00;
            cnt      <= 3'd0;
            wr_q     <= 1'b0;
        end else begin
            case (phase)
                B_IDLE: if (start) begin
                    phase    <= B_REQ;
                    bus_req  <= 1'b1;
                    wr_q     <= wr;
                    addr     <= req_addr;
                    data_out <= req_wdata;
                end
                B_REQ: if (bus_gnt) begin
                    phase <= B_ACT;
                    cs_   <= 1'b0;
                    oe_   <= wr_q;
                    we_   <= !wr_q;
                    cnt   <= wr_q ? 3'd0 : RD_LAST;
                end
                B_ACT: begin
                    if (cnt == 3'd0) begin
                        phase   <= B_IDLE;
                        bus_req <= 1'b0;
                        cs_     <= 1'b1;
                        oe_     <= 1'b1;
                        we_     <= 1'b1;
                        if (!wr_q) rdata <= data_in;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: phase <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_seq.sv
// irq_seq: interrupt entry/exit sequencer between irq_ctrl and the core.
// Entry: ack the controller, read status, hand a vector to the core.
// Exit: EOI write on core request. EOI wins over a new entry in IDLE.
// Optional: define IRQ_SEQ_SPUR_CNT_EN to add a saturating spurious counter
// on output spur_cnt.
module irq_seq
    import irq_seq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 2,
    parameter int          RD_WAIT   = 1,
    parameter logic [7:0]  CTRL_BASE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        irq,
    output logic        irq_ack,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [7:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        cs_,
    output logic        oe_,
    output logic        we_,
    input  logic        core_bnd,
    input  logic        int_en,
    output logic        vec_valid,
    output logic [31:0] vec_addr,
    output logic [4:0]  irq_num,
    input  logic        vec_taken,
    input  logic        eoi_req,
    output logic        eoi_done,
    output logic        busy
`ifdef IRQ_SEQ_SPUR_CNT_EN
    ,
    output logic [7:0]  spur_cnt
`endif
);

    state_t     state;
    logic       bus_start;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic       bus_done;
    logic [7:0] bus_rdata;
    logic       stat_unused;

    // Kick the bus master on the edge that enters RD_REQ or EOI_REQ so its
    // bus_req rises together with the sequencer state
    assign bus_start = (state == S_ACK) || ((state == S_IDLE) && eoi_req);
    assign bus_wr    = (state == S_IDLE);
    assign bus_addr  = bus_wr ? (CTRL_BASE + IRQ_REG_EOI) : (CTRL_BASE + IRQ_REG_STATUS);

    // Status bits 6:5 carry nothing we use
    assign stat_unused = ^bus_rdata[6:5];

    irq_seq_bus #(.RD_WAIT(RD_WAIT)) u_bus (
        .clk       (clk),
        .rst_      (rst_),
        .start     (bus_start),
        .wr        (bus_wr),
        .req_addr  (bus_addr),
        .req_wdata (8'h00),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .cs_       (cs_),
        .oe_       (oe_),
        .we_       (we_),
        .done      (bus_done),
        .rdata     (bus_rdata)
    );

    // Sequencer FSM with registered handshake and vector outputs
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_IDLE;
            irq_ack   <= 1'b0;
            vec_valid <= 1'b0;
            vec_addr  <= 32'd0;
            irq_num   <= 5'd0;
            eoi_done  <= 1'b0;
            busy      <= 1'b0;
`ifdef IRQ_SEQ_SPUR_CNT_EN
            spur_cnt  <= 8'h00;
`endif
        end else begin
            irq_ack  <= 1'b0;
            eoi_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (eoi_req) begin
                        state <= S_EOI_REQ;
                        busy  <= 1'b1;
                    end else if (irq && int_en && core_bnd) begin
                        state   <= S_ACK;
                        irq_ack <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_ACK:    state <= S_RD_REQ;
                S_RD_REQ: if (bus_gnt) state <= S_RD;
                S_RD:     if (bus_done) state <= S_CHK;
                S_CHK: begin
                    if (bus_rdata[STAT_VALID_BIT]) begin
                        irq_num   <= bus_rdata[STAT_NUM_MSB:STAT_NUM_LSB];
                        vec_addr  <= vec_calc(VEC_BASE, bus_rdata[STAT_NUM_MSB:STAT_NUM_LSB], VEC_SHIFT);
                        vec_valid <= 1'b1;
                        state     <= S_VEC;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
`ifdef IRQ_SEQ_SPUR_CNT_EN
                        if (spur_cnt != 8'hFF) spur_cnt <= spur_cnt + 8'd1;
`else
                        // spurious status: nothing to hand to the core
`endif
                    end
                end
                S_VEC: begin
                    if (vec_taken) begin
                        vec_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                S_EOI_REQ: if (bus_gnt) state <= S_EOI_WR;
                S_EOI_WR: begin
                    if (bus_done) begin
                        eoi_done <= 1'b1;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
